// File: rtl/math_pkg.sv
// Shared widths and stage types for the two-stage 16-bit subtractor.
package math_pkg;

  localparam int WIDTH = 16;
  localparam int HALF  = 8;

  // Everything the upper half needs once the lower byte is resolved.
  typedef struct packed {
    logic [HALF-1:0] diff_lo;
    logic            borrow;
    logic [HALF-1:0] op1_hi;
    logic [HALF-1:0] op2_hi;
  } s1_payload_t;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;
    logic             neg;
  } result_t;

  function automatic logic [WIDTH-1:0] sat_value(input logic op1_sign);
    return op1_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

endpackage

// File: rtl/sub_slice_8b.sv
// 8-bit difference slice with borrow chaining and a sign-overflow term.
module sub_slice_8b
  import math_pkg::*;
(
  input  logic [HALF-1:0] a,
  input  logic [HALF-1:0] b,
  input  logic            borrow_in,
  output logic [HALF-1:0] diff,
  output logic            borrow_out,
  output logic            overflow
);

  logic [HALF:0] full;

  // Extra top bit of the widened subtraction is the unsigned borrow.
  assign full       = {1'b0, a} - {1'b0, b} - {{HALF{1'b0}}, borrow_in};
  assign diff       = full[HALF-1:0];
  assign borrow_out = full[HALF];
  assign overflow   = (a[HALF-1] != b[HALF-1]) && (diff[HALF-1] != a[HALF-1]);

endmodule

// File: rtl/pipelined_subtractor_16b.sv
// Two-stage valid/ready 16-bit subtractor split at bit 8.
// Define SUB_SAT_EN to saturate diff_o on signed overflow.
module pipelined_subtractor_16b
  import math_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] op1_i,
  input  logic [15:0] op2_i,
  input  logic        borrow_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] diff_o,
  output logic        borrow_o,
  output logic        overflow_o,
  output logic        zero_o,
  output logic        neg_o
);

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_loads;
  logic        s2_loads;
  s1_payload_t s1_q;
  s1_payload_t s1_d;
  result_t     s2_q;
  result_t     s2_d;

  logic [HALF-1:0]  lo_diff;
  logic             lo_borrow;
  logic             unused_lo_ovf;
  logic [HALF-1:0]  hi_diff;
  logic             hi_borrow;
  logic             hi_ovf;
  logic [WIDTH-1:0] raw_diff;
  logic [WIDTH-1:0] final_diff;

  assign s2_loads   = !s2_valid || out_ready_i;
  assign s1_loads   = !s1_valid || s2_loads;
  assign in_ready_o = s1_loads;

  sub_slice_8b u_slice_lo (
    .a          (op1_i[HALF-1:0]),
    .b          (op2_i[HALF-1:0]),
    .borrow_in  (borrow_i),
    .diff       (lo_diff),
    .borrow_out (lo_borrow),
    .overflow   (unused_lo_ovf)
  );

  always_comb begin
    s1_d         = '0;
    s1_d.diff_lo = lo_diff;
    s1_d.borrow  = lo_borrow;
    s1_d.op1_hi  = op1_i[WIDTH-1:HALF];
    s1_d.op2_hi  = op2_i[WIDTH-1:HALF];
  end

  sub_slice_8b u_slice_hi (
    .a          (s1_q.op1_hi),
    .b          (s1_q.op2_hi),
    .borrow_in  (s1_q.borrow),
    .diff       (hi_diff),
    .borrow_out (hi_borrow),
    .overflow   (hi_ovf)
  );

  assign raw_diff = {hi_diff, s1_q.diff_lo};

`ifdef SUB_SAT_EN
  assign final_diff = hi_ovf ? sat_value(s1_q.op1_hi[HALF-1]) : raw_diff;
`else
  assign final_diff = raw_diff;
`endif

  // Flags describe the value actually presented on diff_o.
  always_comb begin
    s2_d          = '0;
    s2_d.diff     = final_diff;
    s2_d.borrow   = hi_borrow;
    s2_d.overflow = hi_ovf;
    s2_d.zero     = (final_diff == '0);
    s2_d.neg      = final_diff[WIDTH-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_loads) begin
        s1_valid <= in_valid_i;
        if (in_valid_i) s1_q <= s1_d;
      end
      if (s2_loads) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_q <= s2_d;
      end
    end
  end

  assign out_valid_o = s2_valid;
  assign diff_o      = s2_q.diff;
  assign borrow_o    = s2_q.borrow;
  assign overflow_o  = s2_q.overflow;
  assign zero_o      = s2_q.zero;
  assign neg_o       = s2_q.neg;

endmodule

// File: tb/tb_pipelined_subtractor_16b.sv
// Bench for pipelined_subtractor_16b: directed cases, stall, reset flush and random traffic.
module tb_pipelined_subtractor_16b;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] op1_i;
  logic [15:0] op2_i;
  logic        borrow_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] diff_o;
  logic        borrow_o;
  logic        overflow_o;
  logic        zero_o;
  logic        neg_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] diff;
    logic        borrow;
    logic        overflow;
    logic        zero;
    logic        neg;
  } res_t;

  pipelined_subtractor_16b dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .borrow_i    (borrow_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .diff_o      (diff_o),
    .borrow_o    (borrow_o),
    .overflow_o  (overflow_o),
    .zero_o      (zero_o),
    .neg_o       (neg_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int          r;
    logic [15:0] raw;
    res_t        m;
    r          = int'(a) - int'(b) - int'(bin);
    raw        = r[15:0];
    m.borrow   = (r < 0);
    m.overflow = (a[15] != b[15]) && (raw[15] != a[15]);
`ifdef SUB_SAT_EN
    if (m.overflow) raw = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    m.diff = raw;
    m.zero = (raw == 16'h0000);
    m.neg  = raw[15];
    return m;
  endfunction

  function automatic res_t observed();
    return {diff_o, borrow_o, overflow_o, zero_o, neg_o};
  endfunction

  // Stimulus only: one operation with the consumer always ready; starts and ends 1 time unit after a rising edge.
  task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          output res_t r, output int lat);
    int n;
    in_valid_i  = 1'b1;
    op1_i       = a;
    op2_i       = b;
    borrow_i    = bin;
    out_ready_i = 1'b1;
    n = 0;
    while (!in_ready_o && n < 10) begin
      @(posedge clk_i); #1; n++;
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 10) begin
      @(posedge clk_i); #1; lat++;
    end
    r = observed();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    op1_i       = 16'h0;
    op2_i       = 16'h0;
    borrow_i    = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, want 0/1", out_valid_o, in_ready_o);
    end
    checks++;
    if (observed() !== res_t'(0)) begin
      failures++;
      $display("FAIL reset_data: got %h, want 0", observed());
    end
  endtask

  task automatic test_cross_borrow();
    res_t r;
    int   lat;
    send_one(16'h0100, 16'h0001, 1'b0, r, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL cross_borrow_latency: got %0d cycles, want 2", lat);
    end
    checks++;
    if (r.diff !== 16'h00FF || r.borrow !== 1'b0 || r.overflow !== 1'b0) begin
      failures++;
      $display("FAIL cross_borrow_value: diff=%h borrow=%b ovf=%b, want 00ff/0/0", r.diff, r.borrow, r.overflow);
    end
  endtask

  task automatic test_flags();
    res_t r;
    int   lat;
    send_one(16'h0000, 16'h0001, 1'b0, r, lat);
    checks++;
    if (r.diff !== 16'hFFFF || r.borrow !== 1'b1 || r.neg !== 1'b1 || r.overflow !== 1'b0 || r.zero !== 1'b0) begin
      failures++;
      $display("FAIL underflow_flags: got %h, want diff ffff borrow 1 ovf 0 zero 0 neg 1", r);
    end
    send_one(16'h1234, 16'h1234, 1'b0, r, lat);
    checks++;
    if (r.diff !== 16'h0000 || r.zero !== 1'b1 || r.borrow !== 1'b0 || r.neg !== 1'b0) begin
      failures++;
      $display("FAIL equal_zero: got %h, want diff 0000 zero 1", r);
    end
    send_one(16'h0000, 16'h0000, 1'b1, r, lat);
    checks++;
    if (r.diff !== 16'hFFFF || r.borrow !== 1'b1) begin
      failures++;
      $display("FAIL borrow_in: diff=%h borrow=%b, want ffff/1", r.diff, r.borrow);
    end
  endtask

  task automatic test_overflow();
    res_t        r;
    int          lat;
    logic [15:0] want;
`ifdef SUB_SAT_EN
    want = 16'h8000;
`else
    want = 16'h7FFF;
`endif
    send_one(16'h8000, 16'h0001, 1'b0, r, lat);
    checks++;
    if (r.overflow !== 1'b1 || r.borrow !== 1'b0 || r.diff !== want) begin
      failures++;
      $display("FAIL neg_overflow: diff=%h ovf=%b borrow=%b, want %h/1/0", r.diff, r.overflow, r.borrow, want);
    end
`ifdef SUB_SAT_EN
    want = 16'h7FFF;
`else
    want = 16'h8000;
`endif
    send_one(16'h7FFF, 16'hFFFF, 1'b0, r, lat);
    checks++;
    if (r.overflow !== 1'b1 || r.borrow !== 1'b1 || r.diff !== want) begin
      failures++;
      $display("FAIL pos_overflow: diff=%h ovf=%b borrow=%b, want %h/1/1", r.diff, r.overflow, r.borrow, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a[3];
    logic [15:0] b[3];
    logic        bi[3];
    res_t        exp_q[$];
    res_t        held;
    res_t        got_r;
    res_t        want_r;
    int          sent;
    int          got;
    int          c;
    bit          gap;
    for (int i = 0; i < 3; i++) begin
      a[i]  = 16'($urandom);
      b[i]  = 16'($urandom);
      bi[i] = 1'($urandom_range(0, 1));
    end
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    sent = 0;
    op1_i = a[0]; op2_i = b[0]; borrow_i = bi[0];
    c = 0;
    while (sent < 2 && c < 10) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        exp_q.push_back(model(a[sent], b[sent], bi[sent]));
        sent++;
      end
      @(posedge clk_i); #1; c++;
      op1_i = a[sent]; op2_i = b[sent]; borrow_i = bi[sent];
    end
    checks++;
    if (sent != 2 || c != 2) begin
      failures++;
      $display("FAIL fill_accept: accepted %0d in %0d cycles, want 2 in 2", sent, c);
    end
    checks++;
    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL stall_full: in_ready=%b out_valid=%b, want 0/1", in_ready_o, out_valid_o);
    end
    held = observed();
    for (int s = 0; s < 3; s++) begin
      @(posedge clk_i); #1;
      checks++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || observed() !== held) begin
        failures++;
        $display("FAIL stall_hold: cycle %0d out_valid=%b in_ready=%b data=%h, want 1/0/%h",
                 s, out_valid_o, in_ready_o, observed(), held);
      end
    end
    out_ready_i = 1'b1;
    got = 0;
    gap = 1'b0;
    c   = 0;
    while (got < 3 && c < 20) begin
      @(negedge clk_i);
      if (in_valid_i && in_ready_o) begin
        exp_q.push_back(model(a[sent], b[sent], bi[sent]));
        sent++;
      end
      if (out_valid_o && out_ready_i) begin
        got_r  = observed();
        want_r = exp_q.pop_front();
        checks++;
        if (got_r !== want_r) begin
          failures++;
          $display("FAIL drain_order: result %0d got %h, want %h", got, got_r, want_r);
        end
        got++;
      end else if (got > 0) begin
        gap = 1'b1;
      end
      @(posedge clk_i); #1; c++;
      if (sent >= 3) in_valid_i = 1'b0;
    end
    checks++;
    if (got != 3 || gap) begin
      failures++;
      $display("FAIL drain_rate: got %0d results gap=%b, want 3 with no gap", got, gap);
    end
  endtask

  task automatic test_reset_in_flight();
    int stale;
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    op1_i = 16'($urandom); op2_i = 16'($urandom); borrow_i = 1'b0;
    @(posedge clk_i); #1;
    op1_i = 16'($urandom); op2_i = 16'($urandom); borrow_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    rst_i      = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || diff_o !== 16'h0000) begin
      failures++;
      $display("FAIL flush_reset: out_valid=%b in_ready=%b diff=%h, want 0/1/0000", out_valid_o, in_ready_o, diff_o);
    end
    out_ready_i = 1'b1;
    stale = 0;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (out_valid_o) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL flush_stale: %0d stale results, want 0", stale);
    end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    res_t exp_q[$];
    res_t got_r;
    res_t want_r;
    int   acc;
    int   c;
    int   extra;
    acc   = 0;
    c     = 0;
    extra = 0;
    in_valid_i  = 1'b1;
    op1_i       = 16'($urandom);
    op2_i       = 16'($urandom);
    borrow_i    = 1'($urandom_range(0, 1));
    out_ready_i = 1'b1;
    while ((acc < N || exp_q.size() > 0) && c < 40000) begin
      @(negedge clk_i);
      if (in_valid_i && in_ready_o) begin
        exp_q.push_back(model(op1_i, op2_i, borrow_i));
        acc++;
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          got_r  = observed();
          want_r = exp_q.pop_front();
          checks++;
          if (got_r !== want_r) begin
            failures++;
            $display("FAIL random_result: cycle %0d got %h, want %h", c, got_r, want_r);
          end
        end
      end
      @(posedge clk_i); #1; c++;
      in_valid_i  = (acc < N) && ($urandom_range(0, 3) != 0);
      op1_i       = 16'($urandom);
      op2_i       = 16'($urandom);
      borrow_i    = 1'($urandom_range(0, 1));
      out_ready_i = ($urandom_range(0, 3) != 0);
    end
    checks++;
    if (acc != N || exp_q.size() != 0 || extra != 0) begin
      failures++;
      $display("FAIL random_complete: accepted %0d pending %0d extra %0d, want %0d/0/0",
               acc, exp_q.size(), extra, N);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_cross_borrow();
    test_flags();
    test_overflow();
    test_back_to_back();
    test_reset_in_flight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_subtractor_16b.md
PIPELINED_SUBTRACTOR_16B -- requirements
Module: pipelined_subtractor_16b

Interface
REQ-001 Parameters SHALL be none; the datapath width SHALL be fixed at 16 bits and the pipeline split fixed at 8 bits.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 in_valid_o/in_valid_i: in_valid_i  input  1  operand pair presented.
REQ-005 in_ready_o  output  1  block accepts an operand pair this cycle.
REQ-006 op1_i  input  16  minuend.
REQ-007 op2_i  input  16  subtrahend.
REQ-008 borrow_i  input  1  borrow in (subtracted from the result).
REQ-009 out_valid_o  output  1  result presented.
REQ-010 out_ready_i  input  1  consumer accepts the result this cycle.
REQ-011 diff_o  output  16  op1_i - op2_i - borrow_i, modulo 2^16 (saturated when SUB_SAT_EN is defined).
REQ-012 borrow_o  output  1  unsigned borrow out: 1 iff op1_i < op2_i + borrow_i.
REQ-013 overflow_o  output  1  signed overflow of the unsaturated result.
REQ-014 zero_o, neg_o  output  1 each  diff_o == 0; diff_o[15].

Function
REQ-015 Transfer SHALL occur on a cycle with valid and ready both high, on each side independently.
REQ-016 Stage 1 SHALL register diff[7:0], internal borrow from bit 7, and op1[15:8], op2[15:8].
REQ-017 Stage 2 SHALL register diff[15:8] using the stage-1 borrow, plus all flags.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid_o with no stall; throughput 1 per cycle.
REQ-019 Stage-2 SHALL load when empty or when out_ready_i is high; stage 1 SHALL load when empty or stage 2 loads.
REQ-020 in_ready_o SHALL be !s1_valid || s2_loads; there SHALL be no combinational path from op1_i/op2_i/borrow_i to any output.
REQ-021 Under stall (out_ready_i low), out_valid_o and all result outputs SHALL hold stable; at most 2 operations are held; none is lost, duplicated or reordered.
REQ-022 overflow_o SHALL be (op1[15] != op2[15]) && (raw_diff[15] != op1[15]).
REQ-023 Results SHALL be independent of ready/valid timing (same inputs give the same outputs).

Reset
REQ-024 While rst_i is high at a clock edge, both stage valids SHALL clear; out_valid_o = 0, in_ready_o = 1 in the following cycle; data outputs SHALL read 0.
REQ-025 Reset with operations in flight SHALL discard them; no result for them SHALL ever appear.

Configuration
REQ-026 Macro SUB_SAT_EN: when defined, on signed overflow diff_o SHALL be 0x7FFF if op1[15] = 0, else 0x8000; zero_o/neg_o SHALL follow the saturated diff_o.
REQ-027 Without SUB_SAT_EN, diff_o SHALL be the wrapped result; overflow_o, borrow_o behave identically in both builds.

Structure
REQ-028 Shared package math_pkg SHALL hold the width constant (16), half-width (8) and the stage-1 payload struct type.
REQ-029 One sub-module sub_slice_8b SHALL compute an 8-bit difference plus borrow-in/out (plus sign-overflow term) and be instantiated twice.

Verification
REQ-030 0x0100 - 0x0001, borrow_i 0 -> diff 0x00FF, borrow 0, overflow 0, out_valid_o exactly 2 cycles after transfer (cross-stage borrow).
REQ-031 0x0000 - 0x0001 -> diff 0xFFFF, borrow 1, neg 1, overflow 0; 0x1234 - 0x1234 -> 0x0000, zero 1.
REQ-032 0x8000 - 0x0001 -> overflow 1, borrow 0; diff 0x7FFF without SUB_SAT_EN, 0x8000 with it.
REQ-033 Three back-to-back pairs, out_ready_i low 3 cycles -> in_ready_o low after 2 accepted; on release, results emerge in order, one per cycle, outputs stable during stall.
REQ-034 rst_i high for 1 cycle with 2 operations in flight -> next cycle out_valid_o 0, in_ready_o 1; no stale result afterwards.
REQ-035 Random 10k operands with random valid/ready -> every output matches the reference model in order.
